// File: rtl/nios_st_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_st_arb_pkg
// Brief    : Shared widths, FSM state type and rotating priority pick used by
//            the Avalon-ST packet arbiter.
// Revision : 1.0
// ============================================================================
package nios_st_arb_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_ERR_W   = 6;
    localparam int c_EMPTY_W = 2;
    localparam int c_MAX_IN  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First set bit of req found when scanning upward from ptr, wrapping at n.
    function automatic logic [c_MAX_IN-1:0] rr_pick(
        input logic [c_MAX_IN-1:0] req,
        input logic [2:0]          ptr,
        input int unsigned         n
    );
        logic [c_MAX_IN-1:0] win;
        logic                found;
        logic [2:0]          idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < c_MAX_IN; k++) begin
            idx = 3'((32'(ptr) + k) % n);
            if ((k < n) && !found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_st_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : nios_st_rr_picker
// Brief    : Combinational round-robin picker: one-hot winner among requests,
//            searching from the rotating pointer.
// Revision : 1.0
// ============================================================================
module nios_st_rr_picker
    import nios_st_arb_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic              o_any
);

    logic [c_MAX_IN-1:0] w_req8;
    logic [c_MAX_IN-1:0] w_pick8;

    always_comb begin
        w_req8             = '0;
        w_req8[NUM_IN-1:0] = i_req;
    end

    assign w_pick8 = rr_pick(w_req8, 3'(i_ptr), NUM_IN);
    assign o_grant = w_pick8[NUM_IN-1:0];
    assign o_any   = |w_pick8;

endmodule
`default_nettype wire

// File: rtl/nios_avalon_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios_avalon_st_packet_arbiter
// Brief    : Packet-locked round-robin arbiter sharing one Avalon-ST sink among
//            NUM_IN sources. Optional per-input packet counters via
//            NIOS_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module nios_avalon_st_packet_arbiter
    import nios_st_arb_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int DATA_W  = c_DATA_W,
    parameter int ERR_W   = c_ERR_W,
    parameter int EMPTY_W = c_EMPTY_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN*ERR_W-1:0]   in_error,
    input  logic [NUM_IN-1:0]         in_startofpacket,
    input  logic [NUM_IN-1:0]         in_endofpacket,
    input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ERR_W-1:0]          out_error,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    output logic [EMPTY_W-1:0]        out_empty,
    output logic [NUM_IN-1:0]         grant,
`ifdef NIOS_ARB_STATS_EN
    output logic                      proto_err,
    input  logic                      stats_clr,
    output logic [NUM_IN*16-1:0]      pkt_count
`else
    output logic                      proto_err
`endif
);

    localparam int c_PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    state_e              r_state, w_state_nxt;
    logic [NUM_IN-1:0]   r_grant, w_grant_nxt;
    logic [c_PTR_W-1:0]  r_ptr, w_ptr_nxt;
    logic                r_proto_err, w_proto_err_nxt;

    logic [NUM_IN-1:0]   w_req, w_stray, w_pick, w_in_ready;
    logic                w_any;
    logic [c_PTR_W-1:0]  w_owner, w_owner_inc;
    logic                w_valid, w_sop, w_eop, w_eop_acc;
    logic [DATA_W-1:0]   w_data;
    logic [ERR_W-1:0]    w_err;
    logic [EMPTY_W-1:0]  w_empty;

    assign w_req   = in_valid & in_startofpacket;
    assign w_stray = in_valid & ~in_startofpacket;

    nios_st_rr_picker #(
        .NUM_IN (NUM_IN),
        .PTR_W  (c_PTR_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // AND-OR mux keyed on the one-hot grant; reads zero while idle.
    always_comb begin
        w_owner = '0;
        w_valid = 1'b0;
        w_sop   = 1'b0;
        w_eop   = 1'b0;
        w_data  = '0;
        w_err   = '0;
        w_empty = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_grant[i]) begin
                w_owner = c_PTR_W'(i);
                w_valid = w_valid | in_valid[i];
                w_sop   = w_sop | in_startofpacket[i];
                w_eop   = w_eop | in_endofpacket[i];
                w_data  = w_data | in_data[i*DATA_W +: DATA_W];
                w_err   = w_err | in_error[i*ERR_W +: ERR_W];
                w_empty = w_empty | in_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
    end

    assign w_owner_inc = (w_owner == c_PTR_W'(NUM_IN - 1)) ? '0 : w_owner + c_PTR_W'(1);
    assign w_eop_acc   = w_valid & out_ready & w_eop;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_ptr_nxt       = r_ptr;
        w_proto_err_nxt = r_proto_err;
        w_in_ready      = '0;
        case (r_state)
            IDLE: begin
                // Stray non-SOP beats are drained so a broken source cannot block arbitration.
                w_in_ready = w_stray;
                if (|w_stray) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            BUSY: begin
                w_in_ready = r_grant & {NUM_IN{out_ready}};
                if (w_eop_acc) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_owner_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign in_ready          = w_in_ready & {NUM_IN{reset_n}};
    assign out_valid         = w_valid;
    assign out_data          = w_data;
    assign out_error         = w_err;
    assign out_startofpacket = w_sop;
    assign out_endofpacket   = w_eop;
    assign out_empty         = w_empty;
    assign grant             = r_grant;
    assign proto_err         = r_proto_err;

`ifdef NIOS_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (stats_clr) begin
                    r_cnt <= '0;
                end else if (w_eop_acc && r_grant[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign pkt_count[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/nios_avalon_st_packet_arbiter.md
Name: nios_avalon_st_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares one Avalon-ST sink between NUM_IN Avalon-ST sources. The shared sink is the timing adapter in front of the Nios streaming path. Grant is locked from startofpacket through endofpacket, so packets are never interleaved. Payload format matches the stream: 32-bit data, 6-bit error, SOP/EOP and 2-bit empty.

Parameters:
NUM_IN, 2, number of requesting input streams (2..8)
DATA_W, 32, data width
ERR_W, 6, error width
EMPTY_W, 2, empty width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  NUM_IN  per-input valid
in_ready  output  NUM_IN  per-input ready
in_data  input  NUM_IN*DATA_W  packed data, input i at [i*DATA_W +: DATA_W]
in_error  input  NUM_IN*ERR_W  packed error
in_startofpacket  input  NUM_IN  per-input SOP
in_endofpacket  input  NUM_IN  per-input EOP
in_empty  input  NUM_IN*EMPTY_W  packed empty
out_ready  input  1  downstream ready
out_valid  output  1  downstream valid
out_data  output  DATA_W  muxed data
out_error  output  ERR_W  muxed error
out_startofpacket  output  1  muxed SOP
out_endofpacket  output  1  muxed EOP
out_empty  output  EMPTY_W  muxed empty
grant  output  NUM_IN  one-hot current owner; 0 when idle
proto_err  output  1  sticky: non-SOP beat discarded while idle

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, rr_ptr=0, proto_err=0.
  - All outputs read 0 (out_valid, in_ready, payload, grant).
- FSM states: IDLE, BUSY.
- IDLE:
  - Candidates are inputs with in_valid & in_startofpacket.
  - Search order starts at rr_ptr and wraps modulo NUM_IN; first candidate wins.
  - On a win: grant register loads one-hot, state goes to BUSY next edge.
  - Arbitration costs exactly 1 bubble cycle. out_valid=0 in IDLE.
  - An input with in_valid=1 and in_startofpacket=0 in IDLE is a stray beat:
    - in_ready=1 for that input only; the beat is discarded; proto_err set (sticky until reset).
    - Other inputs' in_ready stay 0.
- BUSY (owner g):
  - Combinational pass-through, zero latency:
    - out_valid = in_valid[g]; payload = input g fields.
    - in_ready[g] = out_ready; in_ready of all other inputs = 0.
  - Beat accepted = in_valid[g] & out_ready.
  - Accepted beat with EOP: state to IDLE, grant to 0, rr_ptr = (g+1) mod NUM_IN.
  - SOP on a non-first beat is passed through unchanged; no re-arbitration.
- Single-beat packet (SOP & EOP together): BUSY lasts exactly one accepted cycle, then IDLE.
- out_ready held low: owner stalls indefinitely; grant held; no timeout.
- Payload outputs are don't-care when out_valid=0; the implementation drives the selected input's fields.
- Reset mid-packet: the packet is truncated and the downstream sees no EOP; upstream recovery is the system's responsibility.
- Fairness: a continuously requesting input waits at most NUM_IN-1 packets.

Optional Feature:
NIOS_ARB_STATS_EN
- Defined:
  - Adds output pkt_count, width NUM_IN*16: per-input packet counters.
  - A counter increments on each accepted EOP beat from that input and saturates at 16'hFFFF.
  - Adds input stats_clr (1 bit): synchronous clear; clear wins over a same-cycle increment.
  - Counters reset to 0 on reset_n.
- Undefined: no such ports or logic; behaviour otherwise identical.

Decomposition:
- Package nios_st_arb_pkg holds:
  - Default widths DATA_W/ERR_W/EMPTY_W.
  - State enum (IDLE=1'b0, BUSY=1'b1).
  - Function for a rotating one-hot priority pick.
- One sub-module: nios_st_rr_picker.
  - Combinational; inputs: request vector and rr_ptr.
  - Outputs: one-hot winner and any-valid flag.
- FSM, muxing and stats remain in the top module.

Test Plan:
- Reset/idle: hold reset_n=0 with in_valid=2'b11 -> out_valid=0, in_ready=0, grant=0. Release; both inputs present SOP; rr_ptr=0 -> next cycle grant=2'b01.
- Contention alternation: both inputs send 3-beat packets continuously (data 0xA000_000n on in0, 0xB000_000n on in1) -> output order A,A,A,(bubble),B,B,B,(bubble),A...; never interleaved.
- Backpressure: mid-packet, drop out_ready for 5 cycles -> in_ready[g]=0, out_data stable, grant unchanged; resume, remaining beats delivered in order.
- Single-beat packets: in1 sends SOP+EOP beats back-to-back, in0 idle -> one output beat every 2 cycles, grant toggles 2'b10 -> 0 -> 2'b10.
- Stray beat: in IDLE, in0 valid with SOP=0 -> in_ready[0]=1 for one cycle, out_valid=0, proto_err=1 and stays set until reset.
- Stats (NIOS_ARB_STATS_EN): send 4 packets on in0 and 2 on in1 -> pkt_count[15:0]=4, pkt_count[31:16]=2. Pulse stats_clr on the same cycle as an EOP -> counter reads 0.
